// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scanner.
package sevenseg_pkg;

   typedef enum logic {BLANK = 1'b0, DRIVE = 1'b1} scan_state_e;

   // Hex digit glyphs, bit 6 = segment a ... bit 0 = segment g, 1 = lit.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
      7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
   };

   function automatic int unsigned idx_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sevenseg_prescaler.sv
// Digit-slot prescaler: counts 0..CLK_DIV-1, flags slot end and blank-window end.
module sevenseg_prescaler #(
   parameter int unsigned CLK_DIV      = 100000,
   parameter int unsigned BLANK_CYCLES = 16,
   localparam int unsigned CNT_W       = $clog2(CLK_DIV)
) (
   input  logic             aclk,
   input  logic             aresetn,
   output logic [CNT_W-1:0] count,
   output logic             slot_tick,
   output logic             blank_end
);

   assign slot_tick = (count == CNT_W'(CLK_DIV - 1));
   assign blank_end = (count == CNT_W'(BLANK_CYCLES - 1));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)       count <= '0;
      else if (slot_tick) count <= '0;
      else                count <= count + 1'b1;
   end

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with anti-ghost blanking and double-buffered patterns.
// Optional brightness PWM on the anode is enabled by defining SEVENSEG_DIMMING_EN.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS   = 8,
   parameter int unsigned SEG_W        = 7,
   parameter int unsigned CLK_DIV      = 100000,
   parameter int unsigned BLANK_CYCLES = 16,
   parameter bit          ACTIVE_LOW   = 1'b1,
   localparam int unsigned IDX_W       = idx_width(NUM_DIGITS)
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]       dp_in,
   input  logic [NUM_DIGITS-1:0]       digit_en,
`ifdef SEVENSEG_DIMMING_EN
   input  logic [3:0]                  bright,
`endif
   input  logic                        load,
   output logic [SEG_W-1:0]            cathode,
   output logic                        dp,
   output logic [NUM_DIGITS-1:0]       anode,
   output logic [IDX_W-1:0]            digit_idx,
   output logic                        frame_done,
   output logic                        busy_pending
);

   localparam int unsigned CNT_W = $clog2(CLK_DIV);

   logic [CNT_W-1:0]            presc;
   logic                        slot_tick, blank_end, wrap, dim_on;
   scan_state_e                 state, state_nxt;
   logic [IDX_W-1:0]            idx;
   logic [NUM_DIGITS*SEG_W-1:0] act_seg, shd_seg;
   logic [NUM_DIGITS-1:0]       act_dp, shd_dp;
   logic                        pending;
   logic [NUM_DIGITS-1:0]       anode_nxt;
   logic [SEG_W-1:0]            cathode_nxt;
   logic                        dp_nxt;

   sevenseg_prescaler #(
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_prescaler (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .count     (presc),
      .slot_tick (slot_tick),
      .blank_end (blank_end)
   );

   assign wrap         = slot_tick && (idx == IDX_W'(NUM_DIGITS - 1));
   assign digit_idx    = idx;
   assign busy_pending = pending;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= BLANK;
         idx        <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         frame_done <= wrap;
         if (slot_tick) idx <= wrap ? '0 : idx + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BLANK:   if (blank_end) state_nxt = DRIVE;
         DRIVE:   if (slot_tick) state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase
   end

   // A load coinciding with the frame wrap bypasses the shadow so slot 0 already shows it.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         act_seg <= '0;
         act_dp  <= '0;
         shd_seg <= '0;
         shd_dp  <= '0;
         pending <= 1'b0;
      end else if (load) begin
         shd_seg <= seg_in;
         shd_dp  <= dp_in;
         if (wrap) begin
            act_seg <= seg_in;
            act_dp  <= dp_in;
            pending <= 1'b0;
         end else begin
            pending <= 1'b1;
         end
      end else if (wrap && pending) begin
         act_seg <= shd_seg;
         act_dp  <= shd_dp;
         pending <= 1'b0;
      end
   end

`ifdef SEVENSEG_DIMMING_EN
   // Only consulted in DRIVE, where presc >= BLANK_CYCLES, so the subtraction cannot underflow.
   assign dim_on = ((32'(presc) - BLANK_CYCLES) * 16) < (32'(bright) * (CLK_DIV - BLANK_CYCLES));
`else
   assign dim_on = 1'b1;
`endif

   always_comb begin
      anode_nxt   = '0;
      cathode_nxt = '0;
      dp_nxt      = 1'b0;
      if (state == DRIVE) begin
         cathode_nxt = act_seg[idx*SEG_W +: SEG_W];
         dp_nxt      = act_dp[idx];
         if (digit_en[idx] && dim_on) anode_nxt = NUM_DIGITS'(1) << idx;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         anode   <= {NUM_DIGITS{ACTIVE_LOW}};
         cathode <= {SEG_W{ACTIVE_LOW}};
         dp      <= ACTIVE_LOW;
      end else begin
         anode   <= anode_nxt ^ {NUM_DIGITS{ACTIVE_LOW}};
         cathode <= cathode_nxt ^ {SEG_W{ACTIVE_LOW}};
         dp      <= dp_nxt ^ ACTIVE_LOW;
      end
   end

endmodule

// File: doc/sevenseg_scan_ctrl.md
Name: sevenseg_scan_ctrl

Overview:
Parametrised time-multiplexed seven-segment display scanner for the Nexys4 eight-digit display. Generates its own refresh timing, anode strobes and cathode/DP drive from a bank of per-digit segment patterns. Anti-ghost blanking and tear-free double buffering are built in. Successor to the cathode mux, which needed an externally driven digit select; sits between the ALU result formatter and the board pins.

Parameters:
NUM_DIGITS, 8, digits scanned (2..16)
SEG_W, 7, segment bits per digit (a..g, MSB = a)
CLK_DIV, 100000, aclk cycles per digit slot (>= 4)
BLANK_CYCLES, 16, cycles at slot start with all anodes off (1..CLK_DIV-2)
ACTIVE_LOW, 1, 1 = anode/cathode/dp pins active-low (Nexys4), 0 = active-high

Ports:
aclk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
seg_in  in  NUM_DIGITS*SEG_W  segment patterns, 1 = lit, digit k at [k*SEG_W +: SEG_W]
dp_in  in  NUM_DIGITS  decimal points, 1 = lit
digit_en  in  NUM_DIGITS  1 = digit shown, 0 = anode never asserted for that slot
load  in  1  one-cycle strobe: capture seg_in/dp_in into shadow buffer
cathode  out  SEG_W  segment pins, pin polarity
dp  out  1  decimal point pin, pin polarity
anode  out  NUM_DIGITS  anode pins, pin polarity, at most one active
digit_idx  out  IDX_W  slot currently scanned, IDX_W = max(1,$clog2(NUM_DIGITS))
frame_done  out  1  one-cycle pulse at wrap from last digit to digit 0
busy_pending  out  1  shadow holds data not yet committed

Behaviour:
- Reset (async assert, sync release): prescaler=0, digit_idx=0, state=BLANK, active and shadow buffers cleared (all segments off), pending=0, frame_done=0. All pins inactive: anode, cathode and dp all-1 when ACTIVE_LOW=1, all-0 otherwise.
- Prescaler counts 0..CLK_DIV-1. slot_tick is asserted when it equals CLK_DIV-1; it then wraps to 0.
- FSM, 2 states:
  - BLANK: prescaler < BLANK_CYCLES. Anodes all inactive, cathode/dp inactive. Move to DRIVE when prescaler == BLANK_CYCLES-1.
  - DRIVE: anode[digit_idx] active if digit_en[digit_idx]; cathode/dp = active[digit_idx]. On slot_tick, move to BLANK and advance digit_idx.
- digit_idx increments on slot_tick and wraps NUM_DIGITS-1 -> 0. On the wrap, frame_done pulses for exactly one cycle, concurrent with idx=0.
- All pin outputs are registered, one cycle after the state/idx they reflect. Pin polarity is applied at the output register only.
- load: the shadow buffer captures seg_in/dp_in and pending=1. At a frame wrap with pending=1, shadow is copied to active and pending=0. The display therefore never mixes two loads within one frame.
- load on the wrap cycle: seg_in/dp_in go straight into active (bypass), shadow is also updated, pending=0.
- load repeated before commit: last load wins.
- digit_en changes take effect immediately; they are not buffered.
- Reset asserted mid-slot: all pins go inactive immediately (async); scanning restarts at digit 0 in BLANK.

Optional Feature:
SEVENSEG_DIMMING_EN
- Defined: adds input bright [3:0]. In DRIVE, the anode is active only while (prescaler - BLANK_CYCLES) * 16 < bright * (CLK_DIV - BLANK_CYCLES). bright=0 means fully dark. bright=15 means 15/16 on-time.
- Undefined: no bright port; full on-time for the whole DRIVE window.

Decomposition:
- Package sevenseg_pkg: scan_state_e enum {BLANK, DRIVE}; constant array of 16 hex-to-segment patterns; function idx_width(n).
- One sub-module, sevenseg_prescaler (counter plus slot_tick and blank_end outputs), reused by the dimming compare.

Test Plan:
- Reset hold with NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2 -> anode=4'b1111, cathode=7'h7F, dp=1, digit_idx=0, frame_done=0.
- load seg_in = {7'h06, 7'h5B, 7'h4F, 7'h66} at frame start -> after next wrap, each slot shows all-off for 2 cycles, then anode=~(1<<k) with the matching inverted pattern for 6 cycles; frame_done every 32 cycles.
- digit_en=4'b0101 -> anodes 1 and 3 stay 1 for whole slots; idx still steps through 0..3.
- load mid-frame with new data, then a second load before the wrap -> active unchanged until the wrap, then the second value is shown; busy_pending 1 -> 0 at the wrap.
- load on the exact wrap cycle -> new data visible in slot 0 of that frame; busy_pending stays 0.
- aresetn pulsed low during DRIVE of digit 2 -> pins inactive in the same cycle; after release, idx=0 in BLANK. With SEVENSEG_DIMMING_EN and bright=8, CLK_DIV=34, BLANK_CYCLES=2 -> anode active 16 of 32 DRIVE cycles.
